// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch port: request/grant address phase, then a single-beat response.
// Latency: none (wires only).
// Backpressure: the memory withholds imem_gnt to stall a request; responses cannot be refused.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch unit side: issues requests, consumes grants and responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over imem, buffers {pc, instr} for IF/ID.
// Latency: a response becomes visible on if_valid/if_instruction one cycle after imem_rvalid.
// Backpressure: id_stall holds the buffer head; fetching stops while the buffer plus the outstanding fetch fills it.
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect targets and halt fetching.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_instruction,
  output logic                  if_valid,
  output logic                  fetch_misaligned
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  // IDLE: nothing outstanding. WAIT: granted, response wanted. KILL: granted, response stale.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_KILL = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [1:0]       state_q,  state_d;
  logic [31:0]      pc_q,     pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  fetch_entry_t     buf_q [BUF_DEPTH];
  fetch_entry_t     buf_d [BUF_DEPTH];

  logic        halted;
  logic [31:0] redirect_target;
  logic        issue;
  logic        grant;
  logic        push;
  logic        pop;
  fetch_entry_t head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  // A misaligned target is still loaded into the PC so it can be inspected, but fetching halts.
  assign redirect_target = redirect_pc;

  // Sticky flag: set by a misaligned redirect, cleared only by an aligned one.
  always_comb begin
    misaligned_d = misaligned_q;
    if (redirect_valid) begin
      misaligned_d = |redirect_pc[1:0];
    end
  end

  // Misaligned flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign halted           = misaligned_q;
  assign fetch_misaligned = misaligned_q;
`else
  logic unused_redirect_lsbs;

  // Without the check the target is simply forced onto a word boundary.
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halted               = 1'b0;
  assign fetch_misaligned     = 1'b0;
`endif

  // Only one fetch is ever outstanding and issue happens only in IDLE, so the
  // occupancy test below already accounts for the in-flight fetch: a granted
  // request always has a free slot waiting for its response.
  assign issue = (state_q == ST_IDLE) && (count_q < DEPTH_C) &&
                 !redirect_valid && !halted && !reset;
  assign grant = issue && imem.imem_gnt;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;

  // A redirect squashes both the arriving response and the pop in the same cycle.
  assign push = (state_q == ST_WAIT) && imem.imem_rvalid && !redirect_valid;
  assign pop  = if_valid && !id_stall && !redirect_valid;

  assign head           = buf_q[rd_ptr_q];
  assign if_valid       = (count_q != '0);
  assign if_pc          = if_valid ? head.pc    : 32'h0000_0000;
  assign if_instruction = if_valid ? head.instr : NOP_INSTR;

  // Fetch state machine and PC sequencing; a redirect always wins the PC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          // Response arriving now is simply dropped; otherwise wait for it to drain.
          state_d = imem.imem_rvalid ? ST_IDLE : ST_KILL;
        end else if (imem.imem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      ST_KILL: begin
        if (imem.imem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (redirect_valid) begin
      pc_d = redirect_target;
    end
  end

  // Instruction buffer bookkeeping: write at tail, read at head, flush on redirect.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        buf_d[wr_ptr_q] = '{pc: req_pc_q, instr: imem.imem_rdata};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Buffer storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural memory, expected-instruction queue, cycle table and corner sequences.
// Latency: one check pass per clock, sampled 1ns after the falling edge.
// Backpressure: id_stall and redirect driven from the stimulus; memory grants whenever enabled.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        fetch_misaligned;

  if_fetch_unit_if imem_bus();

  if_fetch_unit #(
    .RESET_PC (RST_PC),
    .BUF_DEPTH(2),
    .NOP_INSTR(NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_stall        (id_stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem            (imem_bus),
    .if_pc           (if_pc),
    .if_instruction  (if_instruction),
    .if_valid        (if_valid),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Expected buffer contents and memory/fetch model.
  ent_t        sb[$];
  logic        pend;
  logic        pend_stale;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] exp_addr;
  logic        exp_halt;
  int          lat;
  logic        gnt_en;
  logic        inject_rv;

  // Snapshot of DUT outputs at the last sample point.
  logic        s_req, s_valid, s_mis, s_gnt_fire;
  logic [31:0] s_addr, s_pc, s_instr;

  vec_t vecs[7];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a << 4) ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset                = 1'b1;
    id_stall             = 1'b0;
    redirect_valid       = 1'b0;
    redirect_pc          = 32'h0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    #1;
    check("rst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
    check("rst_addr",  imem_bus.imem_addr, RST_PC);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_instr", if_instruction, NOP);
    check("rst_mis",   {31'b0, fetch_misaligned}, 32'h0);
    sb.delete();
    pend       = 1'b0;
    pend_stale = 1'b0;
    pend_cnt   = 0;
    pend_addr  = 32'h0;
    exp_addr   = RST_PC;
    exp_halt   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic stall, input logic rv, input logic [31:0] rpc);
    logic        rv_now;
    logic        e_valid;
    logic        e_req;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    @(negedge clk);
    cyc++;
    rv_now    = inject_rv || (pend && pend_cnt == 1);
    inject_rv = 1'b0;
    id_stall             = stall;
    redirect_valid       = rv;
    redirect_pc          = rpc;
    imem_bus.imem_gnt    = gnt_en;
    imem_bus.imem_rvalid = rv_now;
    imem_bus.imem_rdata  = pend ? instr_of(pend_addr) : 32'hBAD0_BAD0;
    #1;
    e_valid = (sb.size() != 0);
    e_pc    = 32'h0;
    e_instr = NOP;
    if (e_valid) begin
      e_pc    = sb[0].pc;
      e_instr = sb[0].instr;
    end
    e_req = !pend && (sb.size() < 2) && !rv && !exp_halt;
    check("valid", {31'b0, if_valid}, {31'b0, e_valid});
    check("if_pc", if_pc, e_pc);
    check("if_instr", if_instruction, e_instr);
    check("req", {31'b0, imem_bus.imem_req}, {31'b0, e_req});
    check("addr", imem_bus.imem_addr, exp_addr);
    check("misaligned", {31'b0, fetch_misaligned}, {31'b0, exp_halt});
    s_req      = imem_bus.imem_req;
    s_addr     = imem_bus.imem_addr;
    s_valid    = if_valid;
    s_pc       = if_pc;
    s_instr    = if_instruction;
    s_mis      = fetch_misaligned;
    s_gnt_fire = imem_bus.imem_req && imem_bus.imem_gnt;
    if (rv) begin
      sb.delete();
      if (pend) begin
        if (rv_now) pend = 1'b0;
        else        pend_stale = 1'b1;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      exp_addr = rpc;
      exp_halt = |rpc[1:0];
`else
      exp_addr = {rpc[31:2], 2'b00};
`endif
    end else begin
      if (e_valid && !stall) void'(sb.pop_front());
      if (rv_now && pend) begin
        if (!pend_stale) sb.push_back('{pc: pend_addr, instr: instr_of(pend_addr)});
        pend = 1'b0;
      end
    end
    if (s_gnt_fire) begin
      pend       = 1'b1;
      pend_stale = 1'b0;
      pend_cnt   = lat;
      pend_addr  = exp_addr;
      exp_addr   = exp_addr + 32'd4;
    end else if (pend && !rv_now) begin
      pend_cnt--;
    end
    @(posedge clk);
  endtask

  initial begin
    logic got;
    reset          = 1'b1;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    lat            = 1;
    gnt_en         = 1'b1;
    inject_rv      = 1'b0;

    // Zero-wait memory after reset: one instruction every two cycles.
    vecs[0] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   NOP};
    vecs[1] = '{1'b0, 1'b0, 32'h104, 1'b0, 32'h0,   NOP};
    vecs[2] = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h100, instr_of(32'h100)};
    vecs[3] = '{1'b0, 1'b0, 32'h108, 1'b0, 32'h0,   NOP};
    vecs[4] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h104, instr_of(32'h104)};
    vecs[5] = '{1'b0, 1'b0, 32'h10C, 1'b0, 32'h0,   NOP};
    vecs[6] = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h108, instr_of(32'h108)};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].stall, 1'b0, 32'h0);
      check("tbl_req",   {31'b0, s_req},   {31'b0, vecs[i].req});
      check("tbl_addr",  s_addr,           vecs[i].addr);
      check("tbl_valid", {31'b0, s_valid}, {31'b0, vecs[i].valid});
      check("tbl_pc",    s_pc,             vecs[i].pc);
      check("tbl_instr", s_instr,          vecs[i].instr);
    end

    // Stall for six cycles: buffer fills to two, fetching stops, head holds.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    check("stall_req_drop", {31'b0, s_req}, 32'h0);
    check("stall_head",     s_pc, 32'h10C);
    step(1'b0, 1'b0, 32'h0);
    check("release_pop0", s_pc, 32'h10C);
    step(1'b0, 1'b0, 32'h0);
    check("release_pop1_valid", {31'b0, s_valid}, 32'h1);
    check("release_pop1", s_pc, 32'h110);

    // Redirect while a slow response is still pending.
    lat = 2;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b0, 32'h0);
      got = s_gnt_fire;
    end
    check("wait_gnt", {31'b0, got}, 32'h1);
    step(1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 32'h0);
    check("redir_flush", {31'b0, s_valid}, 32'h0);
    check("redir_addr",  s_addr, 32'h200);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b0, 32'h0);
      got = s_valid;
    end
    check("redir_first_valid", {31'b0, got}, 32'h1);
    check("redir_first_pc", s_pc, 32'h200);

    // Redirect in the same cycle as a response and a pop.
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (pend && pend_cnt == 1 && !pend_stale && sb.size() == 1) got = 1'b1;
      else step(1'b1, 1'b0, 32'h0);
    end
    check("coinc_setup", {31'b0, got}, 32'h1);
    step(1'b0, 1'b1, 32'h400);
    step(1'b0, 1'b0, 32'h0);
    check("coinc_valid", {31'b0, s_valid}, 32'h0);
    check("coinc_addr",  s_addr, 32'h400);
    check("coinc_req",   {31'b0, s_req}, 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // PC wraps past the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b0, 32'h0);
      got = s_gnt_fire;
    end
    check("wrap_gnt", {31'b0, got}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_addr", s_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Misaligned redirect target.
    step(1'b0, 1'b1, 32'h202);
    step(1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_set",  {31'b0, s_mis}, 32'h1);
    check("mis_halt", {31'b0, s_req}, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    check("mis_still_halt", {31'b0, s_req}, 32'h0);
    step(1'b0, 1'b1, 32'h300);
    step(1'b0, 1'b0, 32'h0);
    check("mis_clear",  {31'b0, s_mis}, 32'h0);
    check("mis_resume", {31'b0, s_req}, 32'h1);
    check("mis_addr",   s_addr, 32'h300);
`else
    check("mis_tied",  {31'b0, s_mis}, 32'h0);
    check("mis_align", s_addr, 32'h200);
    check("mis_req",   {31'b0, s_req}, 32'h1);
`endif
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Random stalls and memory latencies.
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 3);
      step(($urandom_range(0, 3) == 0), 1'b0, 32'h0);
    end

    // Reset in the middle of a fetch; a late response must be ignored.
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b0, 32'h0);
      got = s_gnt_fire;
    end
    check("midrst_gnt", {31'b0, got}, 32'h1);
    lat = 1;
    do_reset();
    inject_rv = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    check("midrst_addr", s_addr, RST_PC);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
